multdiv_sched: RTL and testbench
================================

# multdiv_sched

Sequencer between the execute stage and the shared multi-cycle multiplier/divider. It detects MUL/DIV in D/X and issues a one-cycle start pulse to the multdiv unit. It freezes the front of the pipeline (PC, F/D, D/X) until the result returns or a timeout expires, then supplies the result, or the exception status, to the X/M latch for exactly one cycle. It works alongside the load-use stall logic; the two stall terms are ORed by the pipeline top level.

## Interface
- TIMEOUT, default 40: maximum BUSY cycles before forced exception (≥ 2).
- RSTATUS, default 5'd30: exception destination register.
- MUL_EXC, default 32'd4: status value written on multiply exception/timeout.
- DIV_EXC, default 32'd5: status value written on divide exception/timeout.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- ir_dx  in  32  instruction in D/X; MUL = opcode[31:27]==5'b00000 && aluop[6:2]==5'b00110; DIV = same opcode, aluop 5'b00111.
- flush  in  1  squash D/X (taken branch/jump resolved this cycle).
- data_resultRDY  in  1  multdiv result valid (single-cycle pulse).
- data_exception  in  1  multdiv overflow / divide-by-zero, qualified by data_resultRDY.
- data_result  in  32  multdiv result.
- ctrl_MULT  out  1  start multiply (one-cycle pulse).
- ctrl_DIV  out  1  start divide (one-cycle pulse).
- stall  out  1  hold PC, F/D, D/X; D/X→X/M inserts nothing (the instruction stays in D/X).
- xm_override  out  1  X/M latch takes xm_result/xm_rd instead of the ALU output.
- xm_result  out  32  value for X/M O register.
- xm_rd  out  5  destination for X/M (ir_dx[26:22], or RSTATUS on exception).
- busy  out  1  state != IDLE (debug/perf counter).

## Operation
- States: IDLE, BUSY, DONE. Registers: state, is_div, rd_q[4:0], res_q[32], exc_q, cnt (clog2(TIMEOUT+1) bits).
- IDLE:
  - When (MUL|DIV) && !flush: assert ctrl_MULT or ctrl_DIV and stall, both combinational, this cycle only.
  - Latch is_div, rd_q=ir_dx[26:22], cnt=0. Go to BUSY.
  - Otherwise all outputs 0.
- BUSY:
  - stall=1, cnt increments each cycle.
  - data_resultRDY: res_q=data_result, exc_q=data_exception. Go to DONE.
  - Else if cnt==TIMEOUT-1: exc_q=1. Go to DONE.
  - data_resultRDY on the timeout cycle: the result wins.
- DONE:
  - stall=0, xm_override=1. The instruction advances D/X→X/M this edge.
  - exc_q=0: xm_result=res_q, xm_rd=rd_q.
  - exc_q=1: xm_result=is_div?DIV_EXC:MUL_EXC, xm_rd=RSTATUS.
  - Next state IDLE.
  - Back-to-back MUL/DIV: the next instruction is in D/X only one cycle later, in IDLE, so no same-cycle restart from DONE.
- flush:
  - In BUSY: abort to IDLE, stall deasserts next cycle, no override. Any later data_resultRDY is ignored.
  - In DONE: ignored; the instruction already committed to X/M.
  - In IDLE: suppresses the start.
- rd_q==0: the result is still delivered; register-file $0 write-inhibit handles it.
- Reset (any state, asynchronous): state=IDLE, all registers 0. All outputs 0 immediately. A multdiv op in flight is abandoned, and its later data_resultRDY is ignored in IDLE.

## Timing
- Start latency: 0 cycles. The start pulse is in the same cycle the instruction is seen in D/X.
- Result at data_resultRDY in BUSY cycle k (k≥1 after start):
  - DONE is the following cycle; the override is visible then.
  - Total stall cycles = 1 (start) + k.
- Timeout: stall = 1 + TIMEOUT cycles, then one DONE cycle.
- ctrl_MULT/ctrl_DIV never high for more than one consecutive cycle and never both high.
- stall and xm_override are never high in the same cycle.
- Outputs in IDLE depend combinationally on ir_dx/flush; in BUSY/DONE they depend only on registered state.

## Test plan
- MUL r3=r1*r2 (7×6) in D/X, multdiv RDY after 16 BUSY cycles with 42:
  - ctrl_MULT pulse in cycle 0, stall cycles 0–16.
  - Cycle 17: xm_override=1, xm_result=42, xm_rd=3.
- DIV with data_exception=1 at RDY: DONE gives xm_rd=30, xm_result=5, no write to the original rd.
- DIV with RDY never asserted, TIMEOUT=40: stall high 41 cycles, then xm_rd=30, xm_result=5 for one cycle, then IDLE.
- flush in BUSY cycle 5:
  - Next cycle IDLE, stall=0, no override.
  - A stray RDY in cycle 16 produces no output.
- Back-to-back MUL, MUL:
  - Second ctrl_MULT asserts the cycle after the first DONE.
  - Two override cycles carry correct distinct rd.
- reset asserted low mid-BUSY: all outputs 0 asynchronously. After release, a non-MUL instruction in D/X gives stall=0.

Source files
------------

// File: rtl/multdiv_sched_if.sv
// Handshake bundle between the pipeline, the shared multdiv unit and the
// multiply/divide sequencer. The sequencer uses the slave side; the
// pipeline/multdiv environment drives the master side.
interface multdiv_sched_if;
  logic [31:0] ir_dx;
  logic        flush;
  logic        data_resultRDY;
  logic        data_exception;
  logic [31:0] data_result;
  logic        ctrl_MULT;
  logic        ctrl_DIV;
  logic        stall;
  logic        xm_override;
  logic [31:0] xm_result;
  logic [4:0]  xm_rd;
  logic        busy;

  modport slave (
    input  ir_dx, flush, data_resultRDY, data_exception, data_result,
    output ctrl_MULT, ctrl_DIV, stall, xm_override, xm_result, xm_rd, busy
  );

  modport master (
    output ir_dx, flush, data_resultRDY, data_exception, data_result,
    input  ctrl_MULT, ctrl_DIV, stall, xm_override, xm_result, xm_rd, busy
  );
endinterface

// File: rtl/multdiv_sched.sv
// Multiply/divide sequencer: spots MUL/DIV in D/X, fires a one-cycle start
// pulse at the multdiv unit, freezes the pipeline front until the result
// arrives or the timeout runs out, then drives the X/M latch for one cycle.
module multdiv_sched #(
  parameter int          TIMEOUT = 40,
  parameter logic [4:0]  RSTATUS = 5'd30,
  parameter logic [31:0] MUL_EXC = 32'd4,
  parameter logic [31:0] DIV_EXC = 32'd5
) (
  input logic            clock,
  input logic            reset,
  multdiv_sched_if.slave bus
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t        r_state;
  logic          r_isDiv;
  logic [4:0]    r_rdQ;
  logic [31:0]   r_resQ;
  logic          r_excQ;
  logic [CW-1:0] r_cnt;

  logic w_isMul;
  logic w_isDiv;
  logic w_start;
  logic w_unusedIrBits;

  assign w_isMul = (bus.ir_dx[31:27] == 5'b00000) && (bus.ir_dx[6:2] == 5'b00110);
  assign w_isDiv = (bus.ir_dx[31:27] == 5'b00000) && (bus.ir_dx[6:2] == 5'b00111);
  // Reset gates the start so every output is low the moment reset asserts.
  assign w_start = reset && (r_state == IDLE) && (w_isMul || w_isDiv) && !bus.flush;
  assign w_unusedIrBits = ^{bus.ir_dx[21:7], bus.ir_dx[1:0]};

  // Sequencer state: launch, wait for result or timeout (flush aborts), deliver once.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_isDiv <= 1'b0;
      r_rdQ   <= '0;
      r_resQ  <= '0;
      r_excQ  <= 1'b0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_start) begin
            r_isDiv <= w_isDiv;
            r_rdQ   <= bus.ir_dx[26:22];
            r_excQ  <= 1'b0;
            r_cnt   <= '0;
            r_state <= BUSY;
          end
        end
        BUSY: begin
          r_cnt <= r_cnt + 1'b1;
          if (bus.flush) begin
            r_state <= IDLE;
          end else if (bus.data_resultRDY) begin
            r_resQ  <= bus.data_result;
            r_excQ  <= bus.data_exception;
            r_state <= DONE;
          end else if (r_cnt == LAST) begin
            r_excQ  <= 1'b1;
            r_state <= DONE;
          end
        end
        DONE: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  // Outputs: start/stall follow D/X combinationally in IDLE, otherwise only registered state.
  always_comb begin
    bus.ctrl_MULT   = w_start && w_isMul;
    bus.ctrl_DIV    = w_start && w_isDiv;
    bus.stall       = w_start || (r_state == BUSY);
    bus.xm_override = (r_state == DONE);
    bus.busy        = (r_state != IDLE);
    bus.xm_result   = '0;
    bus.xm_rd       = '0;
    if (r_state == DONE) begin
      if (r_excQ) begin
        bus.xm_result = r_isDiv ? DIV_EXC : MUL_EXC;
        bus.xm_rd     = RSTATUS;
      end else begin
        bus.xm_result = r_resQ;
        bus.xm_rd     = r_rdQ;
      end
    end
  end

endmodule

// File: tb/tb_multdiv_sched.sv
// Directed testbench for the multiply/divide sequencer.
module tb_multdiv_sched;

  logic clock;
  logic reset;
  int   compared;
  int   mismatched;
  int   stallCnt;
  int   pulses;
  int   badCnt;

  multdiv_sched_if bus ();

  multdiv_sched #(
    .TIMEOUT(40),
    .RSTATUS(5'd30),
    .MUL_EXC(32'd4),
    .DIV_EXC(32'd5)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus.slave)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Hard stop if the directed sequence ever wedges.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: observed timeout required finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [31:0] mkOp(input logic [4:0] rd, input logic [4:0] aluop);
    return {5'b00000, rd, 15'b0, aluop, 2'b00};
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic applyStimulus(input logic [31:0] ir, input logic fl, input logic rdy,
                               input logic exc, input logic [31:0] res);
    bus.ir_dx          = ir;
    bus.flush          = fl;
    bus.data_resultRDY = rdy;
    bus.data_exception = exc;
    bus.data_result    = res;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  task automatic checkIdle(input string tag);
    checkOutput({tag, ".stall"}, 32'(bus.stall), 32'd0);
    checkOutput({tag, ".busy"}, 32'(bus.busy), 32'd0);
    checkOutput({tag, ".ovr"}, 32'(bus.xm_override), 32'd0);
    checkOutput({tag, ".mult"}, 32'(bus.ctrl_MULT), 32'd0);
    checkOutput({tag, ".div"}, 32'(bus.ctrl_DIV), 32'd0);
    checkOutput({tag, ".res"}, bus.xm_result, 32'd0);
    checkOutput({tag, ".rd"}, 32'(bus.xm_rd), 32'd0);
  endtask

  // Directed sequence of scenarios, one cycle at a time.
  initial begin
    logic [31:0] nop;
    logic [31:0] mul3, div7, div9, mul4, mul5, mul6, mul8;
    compared   = 0;
    mismatched = 0;
    nop  = 32'h0;
    mul3 = mkOp(5'd3, 5'b00110);
    div7 = mkOp(5'd7, 5'b00111);
    div9 = mkOp(5'd9, 5'b00111);
    mul4 = mkOp(5'd4, 5'b00110);
    mul5 = mkOp(5'd5, 5'b00110);
    mul6 = mkOp(5'd6, 5'b00110);
    mul8 = mkOp(5'd8, 5'b00110);

    // Reset held with a MUL in D/X: nothing may start.
    reset = 1'b0;
    applyStimulus(mul3, 1'b0, 1'b0, 1'b0, 32'd0);
    #3;
    checkIdle("rst");
    #20;
    applyStimulus(nop, 1'b0, 1'b0, 1'b0, 32'd0);
    reset = 1'b1;
    step();
    checkIdle("post_rst");

    // MUL r3 = 7*6, result after 16 BUSY cycles.
    step();
    applyStimulus(mul3, 1'b0, 1'b0, 1'b0, 32'd0);
    #1;
    checkOutput("t1.c0.mult", 32'(bus.ctrl_MULT), 32'd1);
    checkOutput("t1.c0.div", 32'(bus.ctrl_DIV), 32'd0);
    checkOutput("t1.c0.stall", 32'(bus.stall), 32'd1);
    checkOutput("t1.c0.ovr", 32'(bus.xm_override), 32'd0);
    stallCnt = 1;
    pulses   = 0;
    for (int c = 1; c <= 16; c++) begin
      step();
      applyStimulus(mul3, 1'b0, (c == 16), 1'b0, (c == 16) ? 32'd42 : 32'd0);
      #1;
      if (bus.stall) stallCnt++;
      if (bus.ctrl_MULT || bus.ctrl_DIV || bus.xm_override) pulses++;
    end
    checkOutput("t1.stallCycles", 32'(stallCnt), 32'd17);
    checkOutput("t1.busyGlitches", 32'(pulses), 32'd0);
    step();
    applyStimulus(mul3, 1'b0, 1'b0, 1'b0, 32'd0);
    #1;
    checkOutput("t1.c17.ovr", 32'(bus.xm_override), 32'd1);
    checkOutput("t1.c17.stall", 32'(bus.stall), 32'd0);
    checkOutput("t1.c17.res", bus.xm_result, 32'd42);
    checkOutput("t1.c17.rd", 32'(bus.xm_rd), 32'd3);
    checkOutput("t1.c17.mult", 32'(bus.ctrl_MULT), 32'd0);
    step();
    applyStimulus(nop, 1'b0, 1'b0, 1'b0, 32'd0);
    #1;
    checkIdle("t1.c18");

    // Flush in IDLE suppresses the start.
    step();
    applyStimulus(mul3, 1'b1, 1'b0, 1'b0, 32'd0);
    #1;
    checkIdle("fl_idle.c0");
    step();
    applyStimulus(nop, 1'b0, 1'b0, 1'b0, 32'd0);
    #1;
    checkIdle("fl_idle.c1");

    // DIV r7 with exception at RDY (BUSY cycle 3); flush during DONE is ignored.
    step();
    applyStimulus(div7, 1'b0, 1'b0, 1'b0, 32'd0);
    #1;
    checkOutput("t2.c0.div", 32'(bus.ctrl_DIV), 32'd1);
    checkOutput("t2.c0.mult", 32'(bus.ctrl_MULT), 32'd0);
    for (int c = 1; c <= 3; c++) begin
      step();
      applyStimulus(div7, 1'b0, (c == 3), (c == 3), 32'd123);
      #1;
    end
    checkOutput("t2.c3.stall", 32'(bus.stall), 32'd1);
    step();
    applyStimulus(div7, 1'b1, 1'b0, 1'b0, 32'd0);
    #1;
    checkOutput("t2.c4.ovr", 32'(bus.xm_override), 32'd1);
    checkOutput("t2.c4.rd", 32'(bus.xm_rd), 32'd30);
    checkOutput("t2.c4.res", bus.xm_result, 32'd5);
    checkOutput("t2.c4.stall", 32'(bus.stall), 32'd0);
    step();
    applyStimulus(nop, 1'b0, 1'b0, 1'b0, 32'd0);
    #1;
    checkIdle("t2.c5");

    // DIV r9 with no RDY: timeout after 1 + 40 stall cycles.
    step();
    applyStimulus(div9, 1'b0, 1'b0, 1'b0, 32'd0);
    #1;
    checkOutput("t3.c0.div", 32'(bus.ctrl_DIV), 32'd1);
    stallCnt = 1;
    for (int c = 1; c <= 60; c++) begin
      step();
      applyStimulus(div9, 1'b0, 1'b0, 1'b0, 32'd0);
      #1;
      if (!bus.stall) break;
      stallCnt++;
    end
    checkOutput("t3.stallCycles", 32'(stallCnt), 32'd41);
    checkOutput("t3.done.ovr", 32'(bus.xm_override), 32'd1);
    checkOutput("t3.done.rd", 32'(bus.xm_rd), 32'd30);
    checkOutput("t3.done.res", bus.xm_result, 32'd5);
    step();
    applyStimulus(nop, 1'b0, 1'b0, 1'b0, 32'd0);
    #1;
    checkIdle("t3.after");

    // MUL r4 flushed in BUSY cycle 5; stray RDY in cycle 16 is ignored.
    step();
    applyStimulus(mul4, 1'b0, 1'b0, 1'b0, 32'd0);
    #1;
    checkOutput("t4.c0.mult", 32'(bus.ctrl_MULT), 32'd1);
    for (int c = 1; c <= 5; c++) begin
      step();
      applyStimulus(mul4, (c == 5), 1'b0, 1'b0, 32'd0);
      #1;
    end
    checkOutput("t4.c5.stall", 32'(bus.stall), 32'd1);
    step();
    applyStimulus(nop, 1'b0, 1'b0, 1'b0, 32'd0);
    #1;
    checkIdle("t4.c6");
    badCnt = 0;
    for (int c = 7; c <= 17; c++) begin
      step();
      applyStimulus(nop, 1'b0, (c == 16), 1'b0, (c == 16) ? 32'd99 : 32'd0);
      #1;
      if (bus.stall || bus.xm_override || bus.busy || (bus.xm_result != 32'd0)) badCnt++;
    end
    checkOutput("t4.strayRdy", 32'(badCnt), 32'd0);

    // Back-to-back MUL r5 then MUL r6.
    step();
    applyStimulus(mul5, 1'b0, 1'b0, 1'b0, 32'd0);
    #1;
    checkOutput("t5.a.c0.mult", 32'(bus.ctrl_MULT), 32'd1);
    for (int c = 1; c <= 2; c++) begin
      step();
      applyStimulus(mul5, 1'b0, (c == 2), 1'b0, 32'd11);
      #1;
    end
    step();
    applyStimulus(mul5, 1'b0, 1'b0, 1'b0, 32'd0);
    #1;
    checkOutput("t5.a.ovr", 32'(bus.xm_override), 32'd1);
    checkOutput("t5.a.rd", 32'(bus.xm_rd), 32'd5);
    checkOutput("t5.a.res", bus.xm_result, 32'd11);
    checkOutput("t5.a.noRestart", 32'(bus.ctrl_MULT), 32'd0);
    step();
    applyStimulus(mul6, 1'b0, 1'b0, 1'b0, 32'd0);
    #1;
    checkOutput("t5.b.c0.mult", 32'(bus.ctrl_MULT), 32'd1);
    checkOutput("t5.b.c0.stall", 32'(bus.stall), 32'd1);
    checkOutput("t5.b.c0.ovr", 32'(bus.xm_override), 32'd0);
    step();
    applyStimulus(mul6, 1'b0, 1'b1, 1'b0, 32'd22);
    #1;
    checkOutput("t5.b.c1.mult", 32'(bus.ctrl_MULT), 32'd0);
    step();
    applyStimulus(mul6, 1'b0, 1'b0, 1'b0, 32'd0);
    #1;
    checkOutput("t5.b.ovr", 32'(bus.xm_override), 32'd1);
    checkOutput("t5.b.rd", 32'(bus.xm_rd), 32'd6);
    checkOutput("t5.b.res", bus.xm_result, 32'd22);

    // Reset mid-BUSY: outputs drop immediately, later RDY ignored.
    step();
    applyStimulus(mul8, 1'b0, 1'b0, 1'b0, 32'd0);
    #1;
    checkOutput("t6.c0.mult", 32'(bus.ctrl_MULT), 32'd1);
    for (int c = 1; c <= 3; c++) begin
      step();
      applyStimulus(mul8, 1'b0, 1'b0, 1'b0, 32'd0);
      #1;
    end
    checkOutput("t6.c3.busy", 32'(bus.busy), 32'd1);
    #1;
    reset = 1'b0;
    #1;
    checkIdle("t6.rstLow");
    applyStimulus(nop, 1'b0, 1'b0, 1'b0, 32'd0);
    #1;
    reset = 1'b1;
    step();
    applyStimulus(nop, 1'b0, 1'b1, 1'b0, 32'd77);
    #1;
    checkIdle("t6.afterRst");
    step();
    applyStimulus(nop, 1'b0, 1'b0, 1'b0, 32'd0);
    #1;
    checkIdle("t6.afterRdy");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
